lsu: RTL and testbench
======================

# lsu

Load/store unit that turns single CPU memory requests into transactions on the `otter_bus` primary side, directly upstream of the SRAM secondary.
- Write side: places write data on the correct byte lanes.
- Read side: extracts and sign/zero-extends read data from the word returned by the SRAM's registered read port.
- Gates bus strobes on `bus.error`, because the SRAM does not suppress writes on error.
- Returns exactly one response per accepted request.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of `req_addr` and `bus.addr`.
- `BUS_WIDTH`, 32: data width; only 32 is supported.

Ports:
- `clk`  in  1: system clock; the top level drives `bus.clk` from the same net.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: LSU can accept a request; high only in IDLE.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1: zero-extend loads (LBU/LHU).
- `req_addr`  in  `ADDR_WIDTH`: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `resp_valid`  out  1: one-cycle response pulse.
- `resp_rdata`  out  32: extended load data; 0 for stores and errors.
- `resp_error`  out  1: access faulted; qualified by `resp_valid`.
- `bus`  `otter_bus.primary`: drives `addr`, `size`, `rd`, `wr`, `wdata`; samples `rdata`, `error`.

## Operation
- States:
  - IDLE: `req_ready`=1. On `req_valid`, register the request. Next state is ACCESS, or RESP for a locally detected error.
  - ACCESS: bus driven from the registered request. `bus.rd` = !we & !`bus.error`; `bus.wr` = we & !`bus.error`. Sample `bus.error` into the error register.
    - Error: go to RESP.
    - Store: go to RESP.
    - Load: go to DATA.
  - DATA: `bus.rdata` is valid. Format it and register it into `resp_rdata`; go to RESP.
  - RESP: `resp_valid`=1 for one cycle, then IDLE.
- `bus.addr`, `bus.size` and `bus.wdata` hold the registered values in every non-IDLE state. `bus.rd`/`bus.wr` are 0 outside ACCESS.
- Write lanes:
  - byte: `wdata`={4{d[7:0]}}.
  - half: {2{d[15:0]}}.
  - word: d.
  - The SRAM byte enables select the lane.
- Read extraction:
  - `w` = `bus.rdata` >> (8*addr[1:0]).
  - byte: `w[7:0]` extended with `w[7]` or 0.
  - half: `w[15:0]` extended likewise.
  - word: `w`.
- `req_size`=11 always gives a local error: no bus strobe; response in RESP with `resp_error`=1.
- Error response: `resp_rdata`=0, `resp_error`=1, and no `rd`/`wr` strobe is ever emitted for that request.
- `req_valid` while not in IDLE is ignored; `req_ready`=0.

## Timing
- Accept at edge N (`req_valid` & `req_ready`).
- Store: `bus.wr` high in cycle N+1; `resp_valid` in N+2.
- Load: `bus.rd` high in N+1; `rdata` is captured at the end of N+2; `resp_valid` and `resp_rdata` are valid in N+3.
- Bus-detected error: `resp_valid` in N+2.
- Local error (illegal size, or misaligned with the macro on): `resp_valid` in N+1.
- `req_ready` is high again in the cycle after RESP. Minimum spacing between accepts: 3 cycles for stores, 4 for loads.
- Reset values: state IDLE; `req_ready`=1; `resp_valid`=0; `resp_rdata`=0; `resp_error`=0; `bus.rd`=0; `bus.wr`=0; `bus.addr`=0; `bus.size`=0; `bus.wdata`=0.
- Reset asserted mid-transaction:
  - strobes drop immediately;
  - the pending request is discarded with no response;
  - the first accept is possible on the first edge after `rst_n` rises.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - In IDLE, misalignment is checked locally: half with addr[0]=1, or word with addr[1:0]≠00.
  - A misaligned request goes straight to RESP with `resp_error`=1; the bus is never driven with it.
  - Out-of-range faults still come from `bus.error`.
- Undefined: all faults except illegal size come from `bus.error` sampled in ACCESS.
- Both builds return identical response values; only the latency of misaligned errors differs (N+1 vs N+2).

## Structure
- Shared package `mem_pkg`:
  - `mem_size_e` (BYTE=00, HALF=01, WORD=10), shared with the SRAM;
  - `lsu_state_e` (IDLE, ACCESS, DATA, RESP);
  - constant `WORD_BYTES`=4.
- One combinational sub-module, `lsu_lane_fmt`:
  - store lane replication;
  - load shift and extension;
  - inputs: size, unsigned, addr[1:0], `wdata`, `rdata`.
- FSM, request registers and error gating stay in `lsu`.

## Test plan
- Word store then load: store 0xDEADBEEF to 0x100, then load word from 0x100.
  - `bus.wr` high only in N+1, with `wdata`=0xDEADBEEF.
  - Load `resp_rdata`=0xDEADBEEF in N+3.
- Byte/half extension: memory 0x000080F0 at 0x200.
  - LB 0x200 → 0xFFFFFFF0.
  - LBU 0x201 → 0x00000080.
  - LH 0x200 → 0xFFFF80F0.
  - LHU 0x202 → 0x00000000.
- Byte store lane: SB 0xA5 to 0x303.
  - `bus.wdata`=0xA5A5A5A5.
  - Word readback shows 0xA5 only in bits [31:24].
- Bus error gating, macro undefined: SW to 0x102.
  - `bus.wr` stays 0.
  - `resp_error`=1 in N+2.
  - A following load of 0x100 returns the old value.
- Macro defined: LH 0x101 → `resp_error`=1 in N+1, no `bus.rd`. Any request with `req_size`=11 → error, no strobe.
- Reset mid-load: deassert `rst_n` during DATA.
  - `bus.rd`=0 and `resp_valid`=0 immediately.
  - No response after release.
  - The next request completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Types and constants shared by the LSU and the SRAM secondary on otter_bus.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DATA,
    RESP
  } lsu_state_e;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == HALF) && addr_lo[0]) || ((size == WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/otter_bus.sv
// Single-beat memory bus between the LSU (primary) and the SRAM (secondary).
interface otter_bus #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 32
) ();

  logic                  clk;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            size;
  logic                  rd;
  logic                  wr;
  logic [BUS_WIDTH-1:0]  wdata;
  logic [BUS_WIDTH-1:0]  rdata;
  logic                  error;

  modport primary (
    output clk, addr, size, rd, wr, wdata,
    input  rdata, error
  );

  modport secondary (
    input  clk, addr, size, rd, wr, wdata,
    output rdata, error
  );

endinterface

// File: rtl/lsu_lane_fmt.sv
// Combinational byte-lane formatting: store data replication and load shift/extension.
module lsu_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    shifted     = rdata >> {addr_lo, 3'b000};
    wdata_lanes = wdata;
    rdata_ext   = shifted;
    case (size)
      BYTE: begin
        wdata_lanes = {WORD_BYTES{wdata[7:0]}};
        rdata_ext   = {{24{shifted[7] & ~zext}}, shifted[7:0]};
      end
      HALF: begin
        wdata_lanes = {(WORD_BYTES / 2){wdata[15:0]}};
        rdata_ext   = {{16{shifted[15] & ~zext}}, shifted[15:0]};
      end
      default: begin
        wdata_lanes = wdata;
        rdata_ext   = shifted;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one CPU request -> one otter_bus transaction -> one response.
// Optional local misalignment check enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  otter_bus.primary             bus
);

  lsu_state_e state_q, state_d;

  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;

  logic                  local_err;
  logic                  rd_strobe;
  logic                  wr_strobe;
  logic [BUS_WIDTH-1:0]  lane_wdata;
  logic [BUS_WIDTH-1:0]  fmt_rdata;

`ifdef LSU_MISALIGN_CHECK_EN
  assign local_err = (req_size == SIZE_ILLEGAL) || is_misaligned(req_size, req_addr[1:0]);
`else
  assign local_err = (req_size == SIZE_ILLEGAL);
`endif

  lsu_lane_fmt u_lane_fmt (
    .size        (size_q),
    .zext        (uns_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata       (bus.rdata),
    .wdata_lanes (lane_wdata),
    .rdata_ext   (fmt_rdata)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rd_strobe = 1'b0;
    wr_strobe = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          err_d   = local_err;
          if (local_err) begin
            // Locally faulted requests never reach the bus registers.
            state_d = RESP;
          end else begin
            we_d    = req_we;
            size_d  = req_size;
            uns_d   = req_unsigned;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // The SRAM does not suppress writes on error, so strobes are gated here.
        rd_strobe = ~we_q & ~bus.error;
        wr_strobe = we_q & ~bus.error;
        err_d     = bus.error;
        if (bus.error || we_q) begin
          state_d = RESP;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        rdata_d = fmt_rdata;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_error = (state_q == RESP) & err_q;
  assign resp_rdata = rdata_q;

  assign bus.clk   = clk;
  assign bus.addr  = addr_q;
  assign bus.size  = size_q;
  assign bus.wdata = lane_wdata;
  assign bus.rd    = rd_strobe;
  assign bus.wr    = wr_strobe;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: behavioural SRAM secondary, byte-level reference model, per-cycle compare.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  otter_bus #(.ADDR_WIDTH(32), .BUS_WIDTH(32)) bus ();

  lsu #(.ADDR_WIDTH(32), .BUS_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM secondary: 1 KiB, registered read, byte enables, writes even when error is flagged.
  logic [31:0] sram [256];
  assign bus.error = (bus.size == 2'b11) || (bus.size == 2'b01 && bus.addr[0]) ||
                     (bus.size == 2'b10 && bus.addr[1:0] != 2'b00) || (bus.addr >= 32'h400);

  always @(posedge clk) begin
    if (bus.wr) begin
      for (int j = 0; j < 4; j++) begin
        if ((bus.size == 2'b10) ||
            (bus.size == 2'b01 && (j / 2) == int'(bus.addr[1])) ||
            (bus.size == 2'b00 && j == int'(bus.addr[1:0])))
          sram[bus.addr[9:2]][8*j +: 8] <= bus.wdata[8*j +: 8];
      end
    end
    if (bus.rd) bus.rdata <= sram[bus.addr[9:2]];
  end

  // Reference model state: byte memory plus per-cycle expectations.
  logic [7:0]  mem_m [1024];
  int          exp_strobe [int];
  logic [31:0] exp_saddr  [int];
  logic [1:0]  exp_ssize  [int];
  logic [31:0] exp_swdata [int];
  bit          exp_busy   [int];
  logic [31:0] exp_rdata  [int];
  logic        exp_rerr   [int];

  logic [31:0] last_rdata;
  logic        last_err;
  logic [31:0] last_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d: timed out", name, cyc);
  endtask

  always @(negedge clk) begin
    int s;
    s = exp_strobe.exists(cyc) ? exp_strobe[cyc] : 0;
    chk("bus_wr", {31'd0, bus.wr}, {31'd0, s == 1});
    chk("bus_rd", {31'd0, bus.rd}, {31'd0, s == 2});
    if (s != 0) begin
      chk("bus_addr", bus.addr, exp_saddr[cyc]);
      chk("bus_size", {30'd0, bus.size}, {30'd0, exp_ssize[cyc]});
      if (s == 1) begin
        chk("bus_wdata", bus.wdata, exp_swdata[cyc]);
        last_wdata = bus.wdata;
      end
    end
    chk("req_ready", {31'd0, req_ready}, {31'd0, !exp_busy.exists(cyc)});
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_rdata.exists(cyc)});
    if (exp_rdata.exists(cyc)) begin
      chk("resp_rdata", resp_rdata, exp_rdata[cyc]);
      chk("resp_error", {31'd0, resp_error}, {31'd0, exp_rerr[cyc]});
    end
  end

  task automatic model_accept(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] d);
    int n, r, nb;
    logic mis, err, loc;
    logic [31:0] v;
    n   = cyc;
    nb  = (sz == 2'b10) ? 4 : (sz == 2'b01) ? 2 : 1;
    mis = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    err = (sz == 2'b11) || mis || (a >= 32'h400);
    loc = (sz == 2'b11);
`ifdef LSU_MISALIGN_CHECK_EN
    loc = loc || mis;
`endif
    if (loc) r = n + 1;
    else if (err || we) r = n + 2;
    else r = n + 3;
    for (int c = n + 1; c <= r; c++) exp_busy[c] = 1'b1;
    exp_rdata[r] = 32'h0;
    exp_rerr[r]  = err;
    if (!err) begin
      exp_strobe[n+1] = we ? 1 : 2;
      exp_saddr[n+1]  = a;
      exp_ssize[n+1]  = sz;
      if (we) begin
        for (int j = 0; j < 4; j++) v[8*j +: 8] = d[8*(j % nb) +: 8];
        exp_swdata[n+1] = v;
        for (int i = 0; i < nb; i++) mem_m[int'(a) + i] = d[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_m[int'(a) + i];
        if (!uns && nb < 4 && v[8*nb-1])
          for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        exp_rdata[r] = v;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit hold, input bit wait_resp);
    int k;
    bit got;
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      fail_now("ready_wait");
      return;
    end
    model_accept(we, sz, uns, a, d);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = d;
    @(posedge clk);
    #1;
    if (hold) begin
      // A competing request held while busy must be ignored.
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 32'h0;
      req_wdata = 32'hFFFF_FFFF;
      @(posedge clk);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (wait_resp) begin
      k   = 0;
      got = 1'b0;
      while (k < 8 && !got) begin
        @(negedge clk);
        if (resp_valid) begin
          got        = 1'b1;
          last_rdata = resp_rdata;
          last_err   = resp_error;
        end
        k++;
      end
      if (!got) fail_now("resp_wait");
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'h0;
    for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
    last_rdata   = 32'h0;
    last_err     = 1'b0;
    last_wdata   = 32'h0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
    chk("rst_bus_addr", bus.addr, 32'd0);
    chk("rst_bus_size", {30'd0, bus.size}, 32'd0);
    chk("rst_bus_wdata", bus.wdata, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Word store then load.
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("sw_err", {31'd0, last_err}, 32'd0);
    chk("sw_rdata", last_rdata, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1);
    chk("lw_100", last_rdata, 32'hDEAD_BEEF);

    // Byte/half extension.
    do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h0000_80F0, 1'b0, 1'b1);
    do_req(1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 1'b0, 1'b1);
    chk("lb_200", last_rdata, 32'hFFFF_FFF0);
    do_req(1'b0, 2'b00, 1'b1, 32'h201, 32'h0, 1'b0, 1'b1);
    chk("lbu_201", last_rdata, 32'h0000_0080);
    do_req(1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 1'b0, 1'b1);
    chk("lh_200", last_rdata, 32'hFFFF_80F0);
    do_req(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 1'b0, 1'b1);
    chk("lhu_202", last_rdata, 32'h0000_0000);

    // Byte store lane.
    do_req(1'b1, 2'b00, 1'b0, 32'h303, 32'h0000_00A5, 1'b0, 1'b1);
    chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
    do_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 1'b1);
    chk("lw_300", last_rdata, 32'hA500_0000);

    // Half store with a competing request held while busy.
    do_req(1'b1, 2'b01, 1'b0, 32'h306, 32'h0000_BEEF, 1'b1, 1'b0);
    chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 1'b0, 1'b1);
    chk("lw_304", last_rdata, 32'hBEEF_0000);

    // Bus error gating: misaligned word store must not write.
    do_req(1'b1, 2'b10, 1'b0, 32'h102, 32'h1111_1111, 1'b0, 1'b1);
    chk("sw_102_err", {31'd0, last_err}, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1);
    chk("lw_100_kept", last_rdata, 32'hDEAD_BEEF);

    // Misaligned half load, illegal sizes, out of range.
    do_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1'b0, 1'b1);
    chk("lh_101_err", {31'd0, last_err}, 32'd1);
    chk("lh_101_rdata", last_rdata, 32'd0);
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1);
    chk("ld_sz3_err", {31'd0, last_err}, 32'd1);
    do_req(1'b1, 2'b11, 1'b0, 32'h100, 32'h5555_5555, 1'b0, 1'b1);
    chk("st_sz3_err", {31'd0, last_err}, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b0, 1'b1);
    chk("lw_400_err", {31'd0, last_err}, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1);
    chk("lw_100_after_errs", last_rdata, 32'hDEAD_BEEF);

    // Reset asserted during DATA of a load.
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_strobe.delete();
    exp_saddr.delete();
    exp_ssize.delete();
    exp_swdata.delete();
    exp_busy.delete();
    exp_rdata.delete();
    exp_rerr.delete();
    #1;
    chk("midrst_rd", {31'd0, bus.rd}, 32'd0);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, 1'b1);
    chk("lw_200_after_rst", last_rdata, 32'h0000_80F0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
